// File: rtl/mem_arb_pkg.sv
// Shared types and default limits for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_D  = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 255;

  // Which requester owns the memory while the arbiter sits in a BUSY state.
  function automatic arb_owner_t state_owner(input arb_state_t st);
    return (st == BUSY_D) ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Up-counter with clear, optional saturation and a hit flag at LIMIT.
// Used both as the fetch starvation counter and the access watchdog.
module mem_arb_wdog #(
  parameter int LIMIT    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  // Headroom of one count above LIMIT so a non-saturating instance never wraps.
  localparam int CNT_W = $clog2(LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Count register: reset and clear dominate, increment stops at LIMIT when saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && !(SATURATE && hit)) begin
      count_r <= count_r + ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (count_r == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and load/store for one
// unified memory; data has priority, bounded by a fetch starvation limit.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int BE_W = DATA_W / 8;
  // Fetches are always word aligned.
  localparam logic [ADDR_W-1:0] FETCH_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  arb_owner_t winner_s;
  arb_owner_t owner_s;
  logic       launch_s;
  logic       busy_s;
  logic       done_s;
  logic       abort_s;
  logic       starve_hit_s;
  logic       tmo_hit_s;
  logic       starve_clr_s;
  logic       starve_inc_s;

  assign owner_s      = state_owner(state_r);
  assign starve_clr_s = launch_s && ((winner_s == OWN_IF) || !if_req);
  assign starve_inc_s = launch_s && (winner_s == OWN_D) && if_req;

  mem_arb_wdog #(
    .LIMIT    (STARVE_LIMIT),
    .SATURATE (1'b1)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (starve_clr_s),
    .inc (starve_inc_s),
    .hit (starve_hit_s)
  );

  mem_arb_wdog #(
    .LIMIT    (TIMEOUT),
    .SATURATE (1'b0)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (launch_s),
    .inc (busy_s),
    .hit (tmo_hit_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arbitration, completion and watchdog abort decisions.
  always_comb begin
    state_nxt_s = state_r;
    winner_s    = OWN_D;
    launch_s    = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_req && !(starve_hit_s && if_req)) begin
          launch_s    = 1'b1;
          winner_s    = OWN_D;
          state_nxt_s = BUSY_D;
        end else if (if_req) begin
          launch_s    = 1'b1;
          winner_s    = OWN_IF;
          state_nxt_s = BUSY_IF;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_IF, BUSY_D: begin
        busy_s = 1'b1;
        // A ready in the timeout cycle still completes normally.
        if (mem_ready) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (tmo_hit_s) begin
          abort_s     = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Memory-side registers, latched once at launch and held for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= {BE_W{1'b0}};
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else if (launch_s) begin
      mem_en <= 1'b1;
      if (winner_s == OWN_D) begin
        mem_we    <= d_we;
        mem_be    <= d_be;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else begin
        mem_we    <= 1'b0;
        mem_be    <= {BE_W{1'b1}};
        mem_addr  <= if_addr & FETCH_MASK;
        mem_wdata <= {DATA_W{1'b0}};
      end
    end else if (done_s || abort_s) begin
      mem_en <= 1'b0;
    end else begin
      mem_en <= mem_en;
    end
  end

  // Requester-side grant and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      if_gnt    <= launch_s && (winner_s == OWN_IF);
      d_gnt     <= launch_s && (winner_s == OWN_D);
      if_rvalid <= (done_s || abort_s) && (owner_s == OWN_IF);
      d_rvalid  <= (done_s || abort_s) && (owner_s == OWN_D);
      if_err    <= abort_s && (owner_s == OWN_IF);
      d_err     <= abort_s && (owner_s == OWN_D);
    end
  end

  // Read data capture; aborts and stores return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= {DATA_W{1'b0}};
      d_rdata  <= {DATA_W{1'b0}};
    end else if (done_s && (owner_s == OWN_IF)) begin
      if_rdata <= mem_rdata;
    end else if (abort_s && (owner_s == OWN_IF)) begin
      if_rdata <= {DATA_W{1'b0}};
    end else if (done_s && (owner_s == OWN_D)) begin
      d_rdata <= mem_we ? {DATA_W{1'b0}} : mem_rdata;
    end else if (abort_s && (owner_s == OWN_D)) begin
      d_rdata <= {DATA_W{1'b0}};
    end else begin
      if_rdata <= if_rdata;
      d_rdata  <= d_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, latency and a word memory.
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Model state: pending requests, starvation count and memory contents.
  logic        pend_if = 1'b0;
  logic [31:0] pif_addr = 32'h0;
  logic        pend_d = 1'b0;
  logic        pd_we = 1'b0;
  logic [3:0]  pd_be = 4'h0;
  logic [31:0] pd_addr = 32'h0;
  logic [31:0] pd_wdata = 32'h0;
  int          starve_m = 0;
  logic [31:0] mem_m [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_if(input logic [31:0] a);
    pend_if  = 1'b1;
    pif_addr = a;
  endtask

  task automatic new_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd);
    pend_d   = 1'b1;
    pd_we    = we;
    pd_be    = be;
    pd_addr  = a;
    pd_wdata = wd;
  endtask

  // One full access from the IDLE arbitration cycle to the rvalid cycle.
  // w = wait cycles before mem_ready; to = memory never answers.
  task automatic run_access(input int w, input bit to, output bit won_d);
    bit          keep;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata, memval;
    int          busy_len;

    won_d = pend_d && !(starve_m == STARVE && pend_if);
    if_req  = pend_if;
    if_addr = pif_addr;
    d_req   = pend_d;
    d_we    = pd_we;
    d_be    = pd_be;
    d_addr  = pd_addr;
    d_wdata = pd_wdata;
    check("idle_gnt", {62'd0, if_gnt, d_gnt}, 64'd0);

    if (won_d) begin
      e_we = pd_we; e_be = pd_be; e_addr = pd_addr; e_wdata = pd_wdata;
    end else begin
      e_we = 1'b0; e_be = 4'hF; e_addr = {pif_addr[31:2], 2'b00}; e_wdata = 32'h0;
    end

    if (won_d) starve_m = pend_if ? ((starve_m < STARVE) ? starve_m + 1 : STARVE) : 0;
    else       starve_m = 0;

    tick();
    check("gnt", {62'd0, if_gnt, d_gnt}, won_d ? 64'd1 : 64'd2);
    check("en_busy", {63'd0, mem_en}, 64'd1);
    check("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
    check("mem_we", {63'd0, mem_we}, {63'd0, e_we});
    check("mem_be", {60'd0, mem_be}, {60'd0, e_be});
    if (won_d) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_wdata});

    keep = 1'($urandom_range(0, 1));
    if (won_d) pend_d = 1'b0;
    else       pend_if = 1'b0;
    if (!keep) begin
      if (won_d) d_req = 1'b0;
      else       if_req = 1'b0;
    end

    memval   = mem_m[e_addr[5:2]];
    busy_len = to ? TMO + 1 : w + 1;
    for (int j = 1; j <= busy_len; j++) begin
      if (j > 1) begin
        check("busy_gnt", {62'd0, if_gnt, d_gnt}, 64'd0);
        check("busy_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        check("busy_en", {63'd0, mem_en}, 64'd1);
        check("busy_addr", {32'd0, mem_addr}, {32'd0, e_addr});
      end
      mem_ready = !to && (j == busy_len);
      mem_rdata = (mem_ready && !(won_d && e_we)) ? memval : $urandom;
      tick();
      if (j == 1 && keep) begin
        if (won_d) d_req = 1'b0;
        else       if_req = 1'b0;
      end
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;

    e_rdata = (to || (won_d && e_we)) ? 32'h0 : memval;
    check("rvalid", {62'd0, if_rvalid, d_rvalid}, won_d ? 64'd1 : 64'd2);
    check("err", {62'd0, if_err, d_err}, to ? (won_d ? 64'd1 : 64'd2) : 64'd0);
    check("rdata", {32'd0, won_d ? d_rdata : if_rdata}, {32'd0, e_rdata});
    check("en_done", {63'd0, mem_en}, 64'd0);
    check("done_gnt", {62'd0, if_gnt, d_gnt}, 64'd0);

    if (!to && won_d && e_we) begin
      for (int b = 0; b < 4; b++)
        if (e_be[b]) mem_m[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
    end
  endtask

  initial begin
    bit         won;
    logic [5:0] order;
    int         r, w;

    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    mem_m[1] = 32'h0051_3023;

    // Reset state.
    tick(); tick();
    check("rst_en", {63'd0, mem_en}, 64'd0);
    check("rst_outs", {58'd0, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err}, 64'd0);
    check("rst_mem", {mem_addr, mem_wdata}, 64'd0);
    check("rst_mem2", {59'd0, mem_we, mem_be}, 64'd0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    rst = 1'b0;
    tick();

    // Single fetch, two wait cycles.
    new_if(32'h0000_0006);
    run_access(2, 1'b0, won);

    // Simultaneous requests: data first, then fetch.
    new_if($urandom);
    new_d(1'b0, 4'hF, 32'h0000_0010, 32'h0);
    order = 6'd0;
    run_access(1, 1'b0, won); order = {order[4:0], won};
    run_access(0, 1'b0, won); order = {order[4:0], won};
    check("simul_order", {62'd0, order[1:0]}, 64'd2);

    // Store with partial byte enables.
    new_d(1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF);
    run_access(1, 1'b0, won);

    // Timeout on a load, then a normal access.
    new_d(1'b0, 4'hF, 32'h0000_0024, 32'h0);
    run_access(0, 1'b1, won);
    new_d(1'b0, 4'hF, 32'h0000_0104, 32'h0);
    run_access(3, 1'b0, won);

    // Ready arriving in the timeout cycle completes without error.
    new_if(32'h0000_0008);
    run_access(TMO, 1'b0, won);

    // Starvation with data continuously requesting.
    new_if(32'h0000_0030);
    order = 6'd0;
    for (int k = 0; k < 6; k++) begin
      if (!pend_d) new_d(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
      run_access($urandom_range(0, 2), 1'b0, won);
      order = {order[4:0], won};
    end
    check("starve_order", {58'd0, order}, 64'h3D);

    // Reset in the second BUSY cycle drops the access silently.
    new_d(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = pd_addr;
    tick();
    check("mid_gnt", {63'd0, d_gnt}, 64'd1);
    d_req = 1'b0; pend_d = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_en", {63'd0, mem_en}, 64'd0);
    check("mid_rvalid", {60'd0, if_rvalid, d_rvalid, if_err, d_err}, 64'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    starve_m = 0;
    tick();
    check("mid_ready_ign", {61'd0, if_rvalid, d_rvalid, mem_en}, 64'd0);
    tick();
    check("mid_ready_ign2", {61'd0, if_rvalid, d_rvalid, mem_en}, 64'd0);
    mem_ready = 1'b0;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if (!pend_if && $urandom_range(0, 1) == 1) new_if($urandom);
      if (!pend_d && $urandom_range(0, 2) != 0)
        new_d(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
      if (!pend_if && !pend_d) new_if($urandom);
      r = $urandom_range(0, 9);
      w = (r == 7) ? TMO : $urandom_range(0, 3);
      run_access(w, r > 7, won);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-ported unified memory between the processor's instruction-fetch stage and its load/store stage. One access is outstanding at a time. Data accesses have priority over fetches, and a starvation limit bounds how long fetch can be locked out. A watchdog aborts accesses the memory never acknowledges. The block sits between the `processor` core and the memory model, replacing the direct memory connections.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte enables are `DATA_W/8`)
- `STARVE_LIMIT`, 4, maximum consecutive data grants while `if_req` is pending
- `TIMEOUT`, 255, maximum BUSY cycles without `mem_ready` before the access is aborted

Ports:
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  one-cycle grant pulse
- `if_rvalid`  out  1  one-cycle completion pulse
- `if_rdata`  out  DATA_W  fetch data, valid with `if_rvalid`
- `if_err`  out  1  fetch aborted, valid with `if_rvalid`
- `d_req`  in  1  data request; held until `d_gnt`
- `d_we`  in  1  1 = store
- `d_be`  in  DATA_W/8  byte enables
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  one-cycle grant pulse
- `d_rvalid`  out  1  one-cycle completion pulse
- `d_rdata`  out  DATA_W  load data; 0 for stores
- `d_err`  out  1  data access aborted
- `mem_en`  out  1  access active
- `mem_we`  out  1  write strobe
- `mem_be`  out  DATA_W/8  byte enables
- `mem_addr`  out  ADDR_W  address
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ready` is high
- `mem_ready`  in  1  access complete; ignored while `mem_en` is 0

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D. Reset state is IDLE.
- **IDLE, no request:** remain in IDLE.
- **IDLE, request present:**
  - Winner is data if `d_req` is set, unless the starvation counter equals `STARVE_LIMIT` and `if_req` is set; in that case fetch wins.
  - At the clock edge, the winner's address, `we`, `be` and `wdata` are latched into the `mem_*` registers, and the state goes to BUSY_IF or BUSY_D.
  - The winner's `gnt` is registered and pulses in the first BUSY cycle.
- **Fetch latching:** `mem_we` = 0, `mem_be` = all ones, `mem_addr[1:0]` forced to 0. Data address bits pass through unmodified.
- **Starvation counter:**
  - Increments on a data grant while `if_req` = 1.
  - Clears on a fetch grant, or on a data grant while `if_req` = 0.
  - Saturates at `STARVE_LIMIT`.
- **BUSY:**
  - `mem_en` = 1; all `mem_*` outputs stay stable.
  - Requests arriving in this state wait and are arbitrated only in IDLE.
  - `req` may stay high during the `gnt` cycle. The request is not re-granted, because the state is BUSY.
- **Completion:** `mem_ready` = 1 in BUSY.
  - Next cycle: the owner's `rvalid` pulses, `rdata` is registered from `mem_rdata` (0 for stores), `err` = 0.
  - State returns to IDLE, and `mem_en` drops in that same cycle.
- **Watchdog:**
  - Counts BUSY cycles and clears on entry to BUSY.
  - At count `TIMEOUT` with no `mem_ready`: the owner's `rvalid` and `err` pulse, `rdata` = 0, and the state goes to IDLE.
  - If `mem_ready` arrives in the timeout cycle, completion wins and there is no error.
- **Reset mid-access:** the in-flight access is dropped silently, with no `rvalid` or `err`. `mem_en` is 0 in the cycle after `rst` is sampled, and both counters clear.

## Timing
- Every output is registered and resets to 0.
- Grant latency: `gnt` is high 1 cycle after the request is sampled in IDLE.
- Access latency: with `mem_ready` high in BUSY cycle k (k ≥ 1), `rvalid` is high in cycle k+1, which is also the IDLE cycle.
- Throughput: one access per W+2 cycles (W = wait cycles). There is no back-to-back launch.
- Per requester, `gnt` and `rvalid` never overlap. At most one of the two `rvalid` signals is high in any cycle.
- An abort produces `rvalid` exactly `TIMEOUT`+1 cycles after `gnt`.

## Structure
- Package `mem_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, BUSY_IF, BUSY_D);
  - the owner encoding;
  - default constants for `STARVE_LIMIT` and `TIMEOUT`.
- One sub-module, `mem_arb_wdog`: a parameterised up-counter with a clear input and a `hit` output. The arbiter instantiates it twice, once as the starvation counter (saturating) and once as the timeout counter.

## Test plan
- **Single fetch:** `if_req`, `if_addr` = 0x0000_0006; memory acks after 2 wait cycles → `mem_addr` = 0x0000_0004, `mem_be` = 0xF, `if_gnt` at +1, `if_rvalid` at +4, `if_rdata` = `mem_rdata` (0x0051_3023).
- **Simultaneous requests:** `if_req` and `d_req` in the same cycle → data granted first; fetch granted in the IDLE cycle after `d_rvalid`.
- **Starvation:** `d_req` held continuously with `if_req` = 1 and `STARVE_LIMIT` = 4 → grant order D, D, D, D, IF, D…
- **Store:** `d_we` = 1, `d_be` = 0x3, `d_wdata` = 0xDEAD_BEEF, addr 0x100 → `mem_we` = 1 with these exact values, `d_rdata` = 0 with `d_rvalid`.
- **Timeout:** `mem_ready` held at 0, `TIMEOUT` = 8 → `d_rvalid` and `d_err` pulse 9 cycles after `d_gnt`, then the next request is served normally.
- **Reset mid-access:** `rst` asserted in BUSY cycle 2 → `mem_en` = 0 the next cycle, no `rvalid`, and a later `mem_ready` is ignored.
